// File: rtl/router_pkg.sv
// Shared router types: merged DFX flit layout and the null destination address.
package router_pkg;

  localparam int unsigned DATA_WIDTH = 1024;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DFX_WIDTH  = DATA_WIDTH + ADDR_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] dst_addr;
  } dfx_flit_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; storage is not reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/split_addr_data_rx.sv
// Ingress flit buffer: splits merged {data, dst_addr} flits for route compute.
// Optional null-flit dropping is enabled by defining SPLIT_RX_NULL_FILTER_EN.
module split_addr_data_rx
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DFX_WIDTH-1:0]      data_dfx_recv,
  input  logic                      valid_recv,
  output logic                      ready_recv,
  output logic [DATA_WIDTH-1:0]     data_rc,
  output logic [ADDR_WIDTH-1:0]     dst_addr_rc,
  output logic                      valid_rc,
  input  logic                      ready_rc,
  output logic [$clog2(DEPTH):0]    fifo_count
`ifdef SPLIT_RX_NULL_FILTER_EN
  ,
  output logic                      drop_pulse
`endif
);

  dfx_flit_t flit_in;
  dfx_flit_t flit_head;
  logic      full;
  logic      empty;
  logic      accept;
  logic      wr_en;

  assign flit_in    = data_dfx_recv;
  assign ready_recv = !full;
  assign valid_rc   = !empty;
  assign accept     = valid_recv && ready_recv;

`ifdef SPLIT_RX_NULL_FILTER_EN
  logic is_null;
  // Idle flits are handshaken normally but never occupy a slot.
  assign is_null    = (flit_in.dst_addr == ADDR_NULL);
  assign wr_en      = accept && !is_null;
  assign drop_pulse = accept && is_null;
`else
  assign wr_en      = accept;
`endif

  sync_fifo #(
    .WIDTH (DFX_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (valid_rc && ready_rc),
    .wdata (flit_in),
    .rdata (flit_head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Head is masked to zero so stale storage never leaks while empty.
  assign data_rc     = valid_rc ? flit_head.data     : '0;
  assign dst_addr_rc = valid_rc ? flit_head.dst_addr : '0;

endmodule

// File: tb/tb_split_addr_data_rx.sv
// Randomized self-checking bench for split_addr_data_rx against a queue model.
module tb_split_addr_data_rx;
  import router_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef logic [DFX_WIDTH-1:0] flit_vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [DFX_WIDTH-1:0]  data_dfx_recv;
  logic                  valid_recv;
  logic                  ready_recv;
  logic [DATA_WIDTH-1:0] data_rc;
  logic [ADDR_WIDTH-1:0] dst_addr_rc;
  logic                  valid_rc;
  logic                  ready_rc;
  logic [CW-1:0]         fifo_count;
`ifdef SPLIT_RX_NULL_FILTER_EN
  logic                  drop_pulse;
`endif

  always #5 clk = ~clk;

  split_addr_data_rx #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_dfx_recv (data_dfx_recv),
    .valid_recv    (valid_recv),
    .ready_recv    (ready_recv),
    .data_rc       (data_rc),
    .dst_addr_rc   (dst_addr_rc),
    .valid_rc      (valid_rc),
    .ready_rc      (ready_rc),
    .fifo_count    (fifo_count)
`ifdef SPLIT_RX_NULL_FILTER_EN
    ,
    .drop_pulse    (drop_pulse)
`endif
  );

  flit_vec_t model_q[$];
  int        popped_addr[$];
  int        n_checks = 0;
  int        n_pass   = 0;
  logic      last_acc;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic flit_vec_t make_flit(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] d;
    for (int i = 0; i < DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
    return {d, addr};
  endfunction

  function automatic logic is_dropped(input flit_vec_t f);
`ifdef SPLIT_RX_NULL_FILTER_EN
    return f[ADDR_WIDTH-1:0] == '1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    flit_vec_t head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    check("fifo_count", 256'(fifo_count), 256'(model_q.size()));
    check("ready_recv", 256'(ready_recv), 256'(model_q.size() < DEPTH));
    check("valid_rc", 256'(valid_rc), 256'(model_q.size() > 0));
    check("dst_addr_rc", 256'(dst_addr_rc), 256'(head[ADDR_WIDTH-1:0]));
    for (int k = 0; k < DATA_WIDTH / 256; k++)
      check($sformatf("data_rc[%0d]", k), data_rc[k*256 +: 256], head[ADDR_WIDTH + k*256 +: 256]);
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic step(input logic v, input flit_vec_t f, input logic rdy);
    logic pop_now;
    valid_recv    = v;
    data_dfx_recv = f;
    ready_rc      = rdy;
    #1;
    last_acc = v && (model_q.size() < DEPTH);
    pop_now  = rdy && (model_q.size() > 0);
`ifdef SPLIT_RX_NULL_FILTER_EN
    check("drop_pulse", 256'(drop_pulse), 256'(last_acc && is_dropped(f)));
`endif
    @(posedge clk);
    if (pop_now) popped_addr.push_back(int'(model_q.pop_front() & flit_vec_t'({ADDR_WIDTH{1'b1}})));
    if (last_acc && !is_dropped(f)) model_q.push_back(f);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_dut(input int ncyc);
    rst_n      = 1'b0;
    valid_recv = 1'b0;
    ready_rc   = 1'b0;
    repeat (ncyc) begin
      @(posedge clk);
      @(negedge clk);
    end
    model_q.delete();
    check_outputs();
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic drain(input int budget, input logic rand_ready);
    for (int i = 0; i < budget && model_q.size() > 0; i++)
      step(1'b0, '0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    check("drain_empty", 256'(fifo_count), 256'(0));
  endtask

  initial begin
    flit_vec_t f;
    flit_vec_t hold;
    logic      hold_v;
    int        tries;

    rst_n         = 1'b0;
    valid_recv    = 1'b0;
    ready_rc      = 1'b0;
    data_dfx_recv = '0;
    @(negedge clk);

    // Reset values
    reset_dut(3);

    // Single flit, one-cycle latency then gone
    f = {{(DATA_WIDTH/8){8'hA5}}, 10'h2AA};
    step(1'b1, f, 1'b1);
    check("single_addr", 256'(dst_addr_rc), 256'(10'h2AA));
    step(1'b0, '0, 1'b1);
    check("single_gone", 256'(valid_rc), 256'(0));

    // Fill to full; a held fifth flit is refused
    for (int a = 1; a <= 4; a++) step(1'b1, make_flit(ADDR_WIDTH'(a)), 1'b0);
    check("full_ready", 256'(ready_recv), 256'(0));
    f = make_flit(ADDR_WIDTH'(5));
    repeat (3) step(1'b1, f, 1'b0);
    check("full_count", 256'(fifo_count), 256'(4));
    // Pop with the fifth still offered: full blocks write-through
    step(1'b1, f, 1'b1);
    check("full_no_wt", 256'(fifo_count), 256'(3));
    tries = 0;
    do begin step(1'b1, f, 1'b1); tries++; end while (!last_acc && tries < 10);
    drain(20, 1'b0);

    // Simultaneous push and pop at count 2
    step(1'b1, make_flit(ADDR_WIDTH'(11)), 1'b0);
    step(1'b1, make_flit(ADDR_WIDTH'(12)), 1'b0);
    step(1'b1, make_flit(ADDR_WIDTH'(13)), 1'b1);
    check("simul_count", 256'(fifo_count), 256'(2));
    check("simul_head", 256'(dst_addr_rc), 256'(12));
    drain(20, 1'b0);

    // Ten flits with random back-pressure across pointer wrap
    popped_addr.delete();
    for (int a = 0; a < 10; a++) begin
      f = make_flit(ADDR_WIDTH'(a));
      tries = 0;
      do begin step(1'b1, f, 1'($urandom_range(0, 1))); tries++; end
      while (!last_acc && tries < 50);
      if (!last_acc) check("accept_timeout", 256'(0), 256'(1));
    end
    drain(200, 1'b1);
    check("wrap_count", 256'(popped_addr.size()), 256'(10));
    for (int i = 0; i < 10 && i < popped_addr.size(); i++)
      check($sformatf("wrap_order[%0d]", i), 256'(popped_addr[i]), 256'(i));

    // Reset mid-operation at count 3
    for (int a = 0; a < 3; a++) step(1'b1, make_flit(ADDR_WIDTH'(20 + a)), 1'b0);
    check("pre_reset_count", 256'(fifo_count), 256'(3));
    rst_n      = 1'b0;
    valid_recv = 1'b1;
    data_dfx_recv = make_flit(ADDR_WIDTH'(30));
    @(posedge clk);
    model_q.delete();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    valid_recv = 1'b0;

`ifdef SPLIT_RX_NULL_FILTER_EN
    // Null flit handshakes but is not stored
    step(1'b1, make_flit(ADDR_WIDTH'(7)), 1'b0);
    step(1'b1, make_flit(10'h3FF), 1'b0);
    check("null_count", 256'(fifo_count), 256'(1));
    drain(20, 1'b0);
`endif

    // Random traffic; a flit is held until accepted
    hold_v = 1'b0;
    hold   = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_v || last_acc) begin
        hold_v = 1'($urandom_range(0, 3) != 0);
        hold   = make_flit(($urandom_range(0, 7) == 0) ? ADDR_NULL : ADDR_WIDTH'($urandom));
      end
      step(hold_v, hold, 1'($urandom_range(0, 2) != 0));
      if (!hold_v) last_acc = 1'b1;
    end
    drain(50, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
